relin_digit_accumulator: RTL and testbench

- Parametrised successor to the relinearisation front end.
- Consumes tiles of polynomial-multiplier products (decomposed C2 digit × relin key) from an upstream FIFO.
- Per output tile, accumulates NUM_DIGITS consecutive input tiles lane-wise with modular addition mod MODULUS, tags the result with the c0/c1 channel, and emits it over a valid/ready handshake.
- Sequences a whole polynomial (POLY_LENGTH/TILE_WIDTH tiles) per start, and supports flush.

---
 rtl/relin_digit_accumulator.sv | 145 ++++++++++++++
 tb/tb_relin_digit_accumulator.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relin_digit_accumulator.sv
// Relinearisation digit accumulator: sums NUM_DIGITS product tiles lane-wise mod MODULUS
// and streams one accumulated tile per output slot over valid/ready, a polynomial per start.
module relin_digit_accumulator #(
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    TILE_WIDTH  = 8,
    parameter int                    POLY_LENGTH = 512,
    parameter int                    NUM_DIGITS  = 8,
    parameter logic [DATA_WIDTH-1:0] MODULUS     = 64'hFFFF_FFFF_0000_0001,
    localparam int                   NUM_TILES   = POLY_LENGTH / TILE_WIDTH,
    localparam int                   IDX_W       = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             c1_or_c0,
    input  logic                             flush,
    input  logic                             in_valid,
    input  logic [TILE_WIDTH*DATA_WIDTH-1:0] in_data,
    output logic                             dequeue,
    output logic [TILE_WIDTH*DATA_WIDTH-1:0] out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_channel,
    output logic [IDX_W-1:0]                 out_tile_index,
    output logic                             busy,
    output logic                             done
);

    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] TILE_LAST = IDX_W'(NUM_TILES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t state, state_next;

    logic [DIG_W-1:0]                      digit_cnt;
    logic [IDX_W-1:0]                      tile_cnt;
    logic [TILE_WIDTH-1:0][DATA_WIDTH-1:0] acc;
    logic [TILE_WIDTH-1:0][DATA_WIDTH-1:0] acc_next;

    // One extra bit holds the carry so the single conditional subtract is exact for inputs below MODULUS.
    function automatic logic [DATA_WIDTH-1:0] mod_add(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, MODULUS})
            s = s - {1'b0, MODULUS};
        return s[DATA_WIDTH-1:0];
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        dequeue    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start)
                    state_next = ACCUM;
            end
            ACCUM: begin
                dequeue = in_valid;
                if (in_valid && digit_cnt == DIG_LAST)
                    state_next = OUTPUT;
            end
            OUTPUT: begin
                if (out_ready)
                    state_next = (tile_cnt == TILE_LAST) ? IDLE : ACCUM;
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
            dequeue    = 1'b0;
        end
    end

    // The first digit of a tile overwrites, so the previous tile's sum never needs clearing.
    always_comb begin
        acc_next = acc;
        for (int i = 0; i < TILE_WIDTH; i++) begin
            if (digit_cnt == '0)
                acc_next[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            else
                acc_next[i] = mod_add(acc[i], in_data[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            digit_cnt   <= '0;
            tile_cnt    <= '0;
            // NOTE: the accumulator array is reset because it drives out_data, which must read 0 out of reset.
            acc         <= '0;
            out_channel <= 1'b0;
            done        <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            if (flush) begin
                digit_cnt <= '0;
                tile_cnt  <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            out_channel <= c1_or_c0;
                            digit_cnt   <= '0;
                            tile_cnt    <= '0;
                        end
                    end
                    ACCUM: begin
                        if (in_valid) begin
                            acc       <= acc_next;
                            digit_cnt <= (digit_cnt == DIG_LAST) ? '0 : digit_cnt + DIG_W'(1);
                        end
                    end
                    OUTPUT: begin
                        if (out_ready) begin
                            if (tile_cnt == TILE_LAST) begin
                                tile_cnt <= '0;
                                done     <= 1'b1;
                            end else begin
                                tile_cnt <= tile_cnt + IDX_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign out_valid      = (state == OUTPUT);
    assign busy           = (state != IDLE);
    assign out_data       = acc;
    assign out_tile_index = tile_cnt;

endmodule

// File: tb/tb_relin_digit_accumulator.sv
// Scoreboard bench for relin_digit_accumulator: a modelled upstream FIFO feeds digit tiles,
// expected tile sums are queued at load time and popped by a monitor on every output transfer.
module tb_relin_digit_accumulator;

    localparam int     TW  = 8;
    localparam int     ND  = 4;
    localparam int     PL  = 32;
    localparam int     NT  = PL / TW;
    localparam longint MOD = 97;
    localparam int     W   = TW * 64;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         c1_or_c0 = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_ready = 1'b0;
    logic         dequeue;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_channel;
    logic [1:0]   out_tile_index;
    logic         busy;
    logic         done;

    relin_digit_accumulator #(
        .DATA_WIDTH (64),
        .TILE_WIDTH (TW),
        .POLY_LENGTH(PL),
        .NUM_DIGITS (ND),
        .MODULUS    (64'd97)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .c1_or_c0      (c1_or_c0),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .dequeue       (dequeue),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_channel   (out_channel),
        .out_tile_index(out_tile_index),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         chan;
        int           idx;
        bit           last;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] fifo[$];
    bit           pat_q[$];

    int n_tests = 0;
    int n_fail = 0;
    int n_deq = 0;
    int done_count = 0;
    bit pop_pending = 0;
    bit done_due = 0;
    bit start_req = 0;
    bit flush_req = 0;
    bit chan_req = 0;
    bit ready_req = 1;
    bit rand_ready = 0;
    bit rand_gap = 0;

    task automatic check_vec(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle: apply requested controls and FIFO head at negedge, record the pop decision.
    task automatic step();
        bit allow;
        @(negedge clk);
        if (pop_pending) begin
            n_deq++;
            if (fifo.size() > 0) void'(fifo.pop_front());
        end
        start     = start_req;
        flush     = flush_req;
        c1_or_c0  = chan_req;
        start_req = 0;
        flush_req = 0;
        allow = 1;
        if (pat_q.size() > 0) allow = pat_q.pop_front();
        else if (rand_gap)    allow = ($urandom_range(0, 3) != 0);
        in_valid  = allow && (fifo.size() > 0);
        in_data   = (fifo.size() > 0) ? fifo[0] : '0;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_req;
        #1;
        pop_pending = dequeue;
        if (dequeue) check_int("dequeue_needs_in_valid", int'(in_valid), 1);
    endtask

    // kind: 0 random, 1 lane i = i+1, 2 all-96 tile then 50,50,0,0 tile, 3 digits 10,20,30,40 in tile 0
    task automatic load_poly(int kind, bit chan);
        longint       v;
        longint       sum[TW];
        logic [W-1:0] t;
        exp_t         e;
        for (int tile = 0; tile < NT; tile++) begin
            for (int i = 0; i < TW; i++) sum[i] = 0;
            for (int d = 0; d < ND; d++) begin
                for (int i = 0; i < TW; i++) begin
                    v = longint'($urandom_range(0, 96));
                    if (kind == 1) v = i + 1;
                    else if (kind == 2 && tile == 0) v = 96;
                    else if (kind == 2 && tile == 1) v = (d < 2) ? 50 : 0;
                    else if (kind == 3 && tile == 0) v = (d + 1) * 10;
                    sum[i] += v;
                    t[i*64 +: 64] = v;
                end
                fifo.push_back(t);
            end
            for (int i = 0; i < TW; i++) e.data[i*64 +: 64] = sum[i] % MOD;
            e.chan = chan;
            e.idx  = tile;
            e.last = (tile == NT - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic finish_poly(string name);
        int budget = 600;
        while ((exp_q.size() > 0 || busy) && budget > 0) begin
            step();
            budget--;
        end
        check_int({name, "_completes"}, int'(budget > 0), 1);
        step();
        step();
    endtask

    task automatic wait_out_valid(string name);
        int budget = 100;
        while (!out_valid && budget > 0) begin
            step();
            budget--;
        end
        check_int({name, "_reaches_output"}, int'(out_valid), 1);
    endtask

    // Monitor: compare every transferred tile and police the done pulse.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (done) done_count++;
        if (done_due) begin
            check_int("done_after_last", int'(done), 1);
            done_due = 0;
        end else if (done) begin
            check_int("unexpected_done", int'(done), 0);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_int("unexpected_output", int'(out_valid), 0);
            end else begin
                e = exp_q.pop_front();
                check_vec("tile_data", out_data, e.data);
                check_int("tile_channel", int'(out_channel), int'(e.chan));
                check_int("tile_index", int'(out_tile_index), e.idx);
                done_due = e.last;
            end
        end
    end

    initial begin
        int           base;
        int           dc0;
        int           budget;
        logic [W-1:0] cap_data;
        int           cap_idx;

        // Reset values
        #1;
        check_vec("reset_out_data", out_data, '0);
        check_int("reset_out_valid", int'(out_valid), 0);
        check_int("reset_busy", int'(busy), 0);
        check_int("reset_done", int'(done), 0);
        check_int("reset_channel", int'(out_channel), 0);
        check_int("reset_index", int'(out_tile_index), 0);
        repeat (2) step();
        reset = 1'b1;
        step();

        // Basic sum: lane i of every digit = i+1, channel 1
        load_poly(1, 1);
        base = n_deq;
        dc0 = done_count;
        chan_req = 1;
        start_req = 1;
        step();
        finish_poly("basic");
        check_int("basic_dequeues", n_deq - base, NT * ND);
        check_int("basic_done_pulses", done_count - dc0, 1);

        // Modular wrap: 4x96 and 50,50,0,0
        load_poly(2, 0);
        chan_req = 0;
        start_req = 1;
        step();
        finish_poly("wrap");

        // Input gaps on tile 0
        load_poly(3, 1);
        base = n_deq;
        chan_req = 1;
        start_req = 1;
        step();
        pat_q = '{1, 0, 0, 1, 1, 0, 1};
        repeat (7) step();
        step();
        check_int("gap_dequeues", n_deq - base, ND);
        finish_poly("gaps");

        // Backpressure in OUTPUT
        load_poly(0, 0);
        ready_req = 0;
        chan_req = 0;
        start_req = 1;
        step();
        wait_out_valid("bp");
        cap_data = out_data;
        cap_idx  = int'(out_tile_index);
        for (int k = 0; k < 10; k++) begin
            step();
            check_int("bp_valid_held", int'(out_valid), 1);
            check_vec("bp_data_stable", out_data, cap_data);
            check_int("bp_index_stable", int'(out_tile_index), cap_idx);
            check_int("bp_no_dequeue", int'(dequeue), 0);
        end
        ready_req = 1;
        finish_poly("bp");

        // Flush mid tile 1, with an ignored start during ACCUM
        load_poly(0, 1);
        base = n_deq;
        dc0 = done_count;
        chan_req = 1;
        start_req = 1;
        step();
        budget = 50;
        while (n_deq - base < 1 && budget > 0) begin step(); budget--; end
        chan_req = 0;
        start_req = 1;
        step();
        check_int("start_while_busy_channel", int'(out_channel), 1);
        budget = 100;
        while ((n_deq - base) + int'(pop_pending) < ND + 2 && budget > 0) begin step(); budget--; end
        check_int("flush_reached_point", int'(budget > 0), 1);
        flush_req = 1;
        step();
        check_int("flush_blocks_dequeue", int'(dequeue), 0);
        step();
        check_int("flush_busy", int'(busy), 0);
        check_int("flush_out_valid", int'(out_valid), 0);
        check_int("flush_tile1_dequeues", n_deq - base, ND + 2);
        exp_q.delete();
        fifo.delete();
        repeat (3) step();
        check_int("flush_no_done", done_count - dc0, 0);
        load_poly(0, 0);
        chan_req = 0;
        start_req = 1;
        step();
        finish_poly("after_flush");

        // Reset while a tile waits in OUTPUT
        load_poly(0, 1);
        ready_req = 0;
        chan_req = 1;
        start_req = 1;
        step();
        wait_out_valid("rst");
        reset = 1'b0;
        #1;
        check_int("rst_out_valid", int'(out_valid), 0);
        check_vec("rst_out_data", out_data, '0);
        check_int("rst_index", int'(out_tile_index), 0);
        check_int("rst_channel", int'(out_channel), 0);
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_done", int'(done), 0);
        check_int("rst_dequeue", int'(dequeue), 0);
        exp_q.delete();
        fifo.delete();
        repeat (2) step();
        reset = 1'b1;
        pop_pending = 0;
        load_poly(0, 0);
        exp_q.delete();
        ready_req = 1;
        base = n_deq;
        for (int k = 0; k < 5; k++) begin
            step();
            check_int("rst_stays_idle", int'(busy), 0);
        end
        check_int("rst_no_pops", n_deq - base, 0);
        fifo.delete();
        step();

        // Randomised polynomials with input gaps and random backpressure
        rand_gap = 1;
        rand_ready = 1;
        for (int p = 0; p < 3; p++) begin
            chan_req = 1'($urandom_range(0, 1));
            load_poly(0, chan_req);
            start_req = 1;
            step();
            finish_poly("random");
        end
        rand_gap = 0;
        rand_ready = 0;
        step();
        check_int("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
